// File: rtl/fpu_round_pkg.sv
// fpu_round_pkg: shared types and saturation encodings for the FPU rounding stage.
package fpu_round_pkg;
  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100
  } rm_e;
  typedef struct packed {
    logic of;
    logic uf;
    logic nx;
  } flags_t;
  // {exp, frac} of +inf (inf=1) or max-finite (inf=0), right-aligned in 128 bits
  function automatic logic [127:0] sat_enc(input int exp_w, input int man_w, input logic inf);
    logic [127:0] e, f;
    e = (128'd1 << exp_w) - (inf ? 128'd1 : 128'd2);
    f = inf ? '0 : (128'd1 << man_w) - 128'd1;
    return (e << man_w) | f;
  endfunction
endpackage

// File: rtl/fpu_round_pipe_dec.sv
// fpu_round_dec: combinational round-increment and inexact decision.
module fpu_round_dec
  import fpu_round_pkg::*;
(
  input  logic       sign,
  input  logic [2:0] rm,
  input  logic       lsb,
  input  logic       g,
  input  logic       s,
  output logic       inc,
  output logic       nx
);
  always_comb begin
    nx  = g | s;
    inc = rm == RTZ ? 1'b0 :
          rm == RDN ? sign & nx :
          rm == RUP ? !sign & nx :
          rm == RMM ? g :
          g & (s | lsb);
  end
endmodule

// File: rtl/fpu_round_pipe.sv
// fpu_round_pipe: two-stage IEEE-754 rounding with overflow saturation and valid/ready flow.
module fpu_round_pipe
  import fpu_round_pkg::*;
#(
  parameter int EXP_W = 11,
  parameter int MAN_W = 52,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     sign_i,
  input  logic [EXP_W:0]           exp_i,
  input  logic [MAN_W+2:0]         mant_i,
  input  logic [2:0]               rm_i,
  input  logic [TAG_W-1:0]         tag_i,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     result_o,
  output logic [2:0]               flags_o,
  output logic [TAG_W-1:0]         tag_o
);
  localparam logic [127:0] INF_ENC = sat_enc(EXP_W, MAN_W, 1'b1);
  localparam logic [127:0] MAX_ENC = sat_enc(EXP_W, MAN_W, 1'b0);
  logic                   s1_valid, s2_valid, s1_en, s2_en, inc, nx;
  logic [MAN_W+1:0]       s1_sum;
  logic [EXP_W:0]         s1_exp;
  logic                   s1_sign, s1_nx, s1_tiny;
  logic [2:0]             s1_rm;
  logic [TAG_W-1:0]       s1_tag;
  logic [EXP_W+1:0]       exp_f;
  logic [MAN_W-1:0]       frac_f;
  logic                   ovf, to_inf;
  logic [EXP_W+MAN_W-1:0] mag;
  flags_t                 fl;
  assign s2_en     = !s2_valid | out_ready;
  assign s1_en     = !s1_valid | s2_en;
  assign in_ready  = s1_en;
  assign out_valid = s2_valid;
  fpu_round_dec u_dec (
    .sign (sign_i),
    .rm   (rm_i),
    .lsb  (mant_i[2]),
    .g    (mant_i[1]),
    .s    (mant_i[0]),
    .inc  (inc),
    .nx   (nx)
  );
  // exponent is widened by one bit so the carry increment can never wrap
  always_comb begin
    exp_f  = s1_sum[MAN_W+1] ? {1'b0, s1_exp} + {{(EXP_W+1){1'b0}}, 1'b1} :
             (s1_exp == '0 && s1_sum[MAN_W]) ? {{(EXP_W+1){1'b0}}, 1'b1} :
             {1'b0, s1_exp};
    frac_f = s1_sum[MAN_W+1] ? s1_sum[MAN_W:1] : s1_sum[MAN_W-1:0];
    ovf    = exp_f >= {2'b00, {EXP_W{1'b1}}};
    to_inf = !(s1_rm == RTZ || (s1_rm == RUP && s1_sign) || (s1_rm == RDN && !s1_sign));
    mag    = !ovf ? {exp_f[EXP_W-1:0], frac_f} :
             to_inf ? INF_ENC[EXP_W+MAN_W-1:0] : MAX_ENC[EXP_W+MAN_W-1:0];
    fl     = '{of: ovf, uf: s1_tiny & (s1_nx | ovf), nx: s1_nx | ovf};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      s1_exp   <= '0;
      s1_sign  <= 1'b0;
      s1_rm    <= '0;
      s1_nx    <= 1'b0;
      s1_tiny  <= 1'b0;
      s1_tag   <= '0;
      s2_valid <= 1'b0;
      result_o <= '0;
      flags_o  <= '0;
      tag_o    <= '0;
    end else begin
      if (s1_en) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_sum  <= {1'b0, mant_i[MAN_W+2:2]} + {{(MAN_W+1){1'b0}}, inc};
          s1_exp  <= exp_i;
          s1_sign <= sign_i;
          s1_rm   <= rm_i;
          s1_nx   <= nx;
          s1_tiny <= exp_i == '0 && !mant_i[MAN_W+2];
          s1_tag  <= tag_i;
        end
      end
      if (s2_en) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          result_o <= {s1_sign, mag};
          flags_o  <= fl;
          tag_o    <= s1_tag;
        end
      end
    end
  end
endmodule

// File: tb/tb_fpu_round_pipe.sv
// tb_fpu_round_pipe: random and directed checks of fpu_round_pipe against a value-level model.
module tb_fpu_round_pipe;
  localparam logic [51:0] ONES = {52{1'b1}};
  logic        clk = 0, rst = 1, in_valid = 0, out_ready = 0, sign_i = 0;
  logic [11:0] exp_i = 0;
  logic [54:0] mant_i = 0;
  logic [2:0]  rm_i = 0;
  logic [3:0]  tag_i = 0;
  logic        in_ready, out_valid;
  logic [63:0] result_o;
  logic [2:0]  flags_o;
  logic [3:0]  tag_o;
  int          n_cmp = 0, n_err = 0, n_out = 0;
  logic [70:0] q[$];
  logic [70:0] head, held_val;
  logic        held = 0;

  fpu_round_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sign_i(sign_i), .exp_i(exp_i), .mant_i(mant_i), .rm_i(rm_i), .tag_i(tag_i),
    .out_valid(out_valid), .out_ready(out_ready), .result_o(result_o),
    .flags_o(flags_o), .tag_o(tag_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  // value-level rounding: integer significand plus increment, then renormalise and saturate
  function automatic logic [66:0] model(input logic s, input logic [11:0] e, input logic [54:0] m,
                                        input logic [2:0] rm);
    logic        g, st, inc, nx, of, uf, up;
    logic [63:0] sig, res;
    int          ex;
    g  = m[1];
    st = m[0];
    case (rm)
      3'd1:    inc = 0;
      3'd2:    inc = s & (g | st);
      3'd3:    inc = !s & (g | st);
      3'd4:    inc = g;
      default: inc = g & (st | m[2]);
    endcase
    sig = {11'b0, m[54:2]} + {63'b0, inc};
    ex  = int'(e);
    if (sig >= (64'd1 << 53)) begin
      sig = sig >> 1;
      ex++;
    end else if (ex == 0 && sig >= (64'd1 << 52)) ex = 1;
    nx = g | st;
    of = 0;
    res = {s, ex[10:0], sig[51:0]};
    if (ex >= 2047) begin
      of = 1;
      nx = 1;
      up = rm == 3'd1 ? 1'b0 : rm == 3'd2 ? s : rm == 3'd3 ? !s : 1'b1;
      res = up ? {s, 11'h7FF, 52'h0} : {s, 11'h7FE, ONES};
    end
    uf = e == 0 && !m[54] && nx;
    return {res, of, uf, nx};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      held = 0;
    end else begin
      if (held) chk("hold", {out_valid, tag_o, result_o, flags_o}, {1'b1, held_val});
      if (out_valid && out_ready) begin
        n_out++;
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL spurious: got tag %h result %h with no beat outstanding", tag_o, result_o);
        end else begin
          head = q.pop_front();
          chk("out", {tag_o, result_o, flags_o}, head);
        end
      end
      if (in_valid && in_ready) q.push_back({tag_i, model(sign_i, exp_i, mant_i, rm_i)});
      held     = out_valid && !out_ready;
      held_val = {tag_o, result_o, flags_o};
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid  = 0;
      out_ready = 1;
    end
  endtask

  task automatic single(input string name, input logic s, input logic [11:0] e, input logic [54:0] m,
                        input logic [2:0] rm, input logic [63:0] wr, input logic [2:0] wf);
    chk({name, " model"}, model(s, e, m, rm), {wr, wf});
    idle(3);
    @(posedge clk); #1;
    in_valid = 1; sign_i = s; exp_i = e; mant_i = m; rm_i = rm; tag_i = 4'($urandom);
    @(posedge clk); #1;
    in_valid = 0;
    @(negedge clk);
    chk({name, " lat1"}, out_valid, 0);
    @(negedge clk);
    chk({name, " out"}, {out_valid, result_o, flags_o}, {1'b1, wr, wf});
  endtask

  task automatic rnd_beat();
    logic [63:0] r;
    r = {32'($urandom), 32'($urandom)};
    case ($urandom_range(0, 4))
      0:       exp_i = 12'h000;
      1:       exp_i = 12'h3FF;
      2:       exp_i = 12'h7FE;
      3:       exp_i = 12'h7FF;
      default: exp_i = 12'($urandom_range(0, 4095));
    endcase
    mant_i  = {exp_i != 0, $urandom_range(0, 1) ? ONES : r[51:0], 1'($urandom), 1'($urandom)};
    sign_i  = 1'($urandom);
    rm_i    = 3'($urandom_range(0, 7));
    tag_i   = 4'($urandom);
  endtask

  initial begin
    int acc, cyc;
    logic ir;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset outputs", {out_valid, result_o, flags_o, tag_o}, 0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("ready after reset", in_ready, 1);

    single("rne tie lsb1", 0, 12'h3FF, {1'b1, 52'h1, 2'b10}, 3'd0, 64'h3FF0000000000002, 3'b001);
    single("rne tie lsb0", 0, 12'h3FF, {1'b1, 52'h0, 2'b10}, 3'd0, 64'h3FF0000000000000, 3'b001);
    single("rmm tie", 0, 12'h3FF, {1'b1, 52'h0, 2'b10}, 3'd4, 64'h3FF0000000000001, 3'b001);
    single("carry out", 0, 12'h3FF, {1'b1, ONES, 2'b11}, 3'd0, 64'h4000000000000000, 3'b001);
    single("ovf rne", 0, 12'h7FE, {1'b1, ONES, 2'b10}, 3'd0, 64'h7FF0000000000000, 3'b101);
    single("rtz below ovf", 0, 12'h7FE, {1'b1, ONES, 2'b10}, 3'd1, 64'h7FEFFFFFFFFFFFFF, 3'b001);
    single("rup neg below ovf", 1, 12'h7FE, {1'b1, ONES, 2'b10}, 3'd3, 64'hFFEFFFFFFFFFFFFF, 3'b001);
    single("ovf rtz sat", 0, 12'h7FF, {1'b1, 52'h0, 2'b00}, 3'd1, 64'h7FEFFFFFFFFFFFFF, 3'b101);
    single("ovf rup neg sat", 1, 12'h7FF, {1'b1, 52'h0, 2'b01}, 3'd3, 64'hFFEFFFFFFFFFFFFF, 3'b101);
    single("ovf rdn neg inf", 1, 12'h7FF, {1'b1, 52'h0, 2'b00}, 3'd2, 64'hFFF0000000000000, 3'b101);
    single("subnormal promote", 0, 12'h000, {1'b0, ONES, 2'b10}, 3'd0, 64'h0010000000000000, 3'b011);
    single("exact", 0, 12'h3FF, {1'b1, 52'h5, 2'b00}, 3'd3, 64'h3FF0000000000005, 3'b000);
    single("rsvd rm as rne", 0, 12'h3FF, {1'b1, 52'h1, 2'b10}, 3'd7, 64'h3FF0000000000002, 3'b001);

    // backpressure: output stalled for three cycles while four beats stream in
    idle(3);
    acc = n_out;
    cyc = 0;
    for (int t = 0; t < 4; t++) begin
      ir = 0;
      while (!ir && cyc < 40) begin
        @(posedge clk); #1;
        out_ready = cyc >= 3;
        in_valid = 1; rnd_beat(); tag_i = 4'(t);
        @(negedge clk);
        ir = in_ready;
        if (cyc == 2) chk("stall in_ready", in_ready, 0);
        cyc++;
      end
    end
    chk("stall accept bound", cyc < 40, 1);
    idle(4);
    chk("stall beats out", n_out - acc, 4);

    // reset with two beats in flight
    idle(3);
    for (int t = 0; t < 2; t++) begin
      @(posedge clk); #1;
      out_ready = 0; in_valid = 1; rnd_beat();
    end
    @(posedge clk); #1;
    in_valid = 0; rst = 1;
    @(posedge clk); #1;
    rst = 0; out_ready = 1;
    @(negedge clk);
    chk("flush outputs", {out_valid, result_o, flags_o, tag_o}, 0);
    chk("flush ready", in_ready, 1);
    acc = n_out;
    idle(4);
    chk("flushed beats gone", n_out - acc, 0);

    // random traffic with random backpressure
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      in_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      rnd_beat();
    end
    idle(6);
    chk("drain", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
